// File: rtl/multi_peak_finder_if.sv
// Sample/result bundle for multi_peak_finder.
// The master side drives the sample stream and threshold; the slave side
// (the peak finder) returns the done strobe and the sorted top-K table.
interface multi_peak_finder_if #(
    parameter int DATA_W    = 18,
    parameter int IDX_W     = 12,
    parameter int NUM_PEAKS = 4,
    parameter int CNT_W     = $clog2(NUM_PEAKS + 1)
);
    logic                          enable;
    logic                          start;
    logic [DATA_W-1:0]             data_in;
    logic [DATA_W-1:0]             thresh;
    logic                          done;
    logic [CNT_W-1:0]              peak_count;
    logic [IDX_W*NUM_PEAKS-1:0]    peak_index;
    logic [DATA_W*NUM_PEAKS-1:0]   peak_mag;

    modport master (
        output enable,
        output start,
        output data_in,
        output thresh,
        input  done,
        input  peak_count,
        input  peak_index,
        input  peak_mag
    );

    modport slave (
        input  enable,
        input  start,
        input  data_in,
        input  thresh,
        output done,
        output peak_count,
        output peak_index,
        output peak_mag
    );
endinterface

// File: rtl/multi_peak_finder.sv
// Streaming top-K peak finder for spectral frames.
// One unsigned magnitude is accepted per enabled clock. Local maxima at or
// above a runtime threshold are inserted into a small table kept sorted by
// descending magnitude (earlier index wins ties). At frame end the table is
// copied to the result registers together with a one-cycle done strobe.
module multi_peak_finder #(
    parameter int DATA_W    = 18,
    parameter int IDX_W     = 12,
    parameter int FRAME_LEN = 4096,
    parameter int NUM_PEAKS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multi_peak_finder_if.slave   bus
);
    localparam int CNT_W = $clog2(NUM_PEAKS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_PEAKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;

    // Index of the next sample to arrive, plus the two previous samples.
    logic [IDX_W-1:0]        idx_r;
    logic [DATA_W-1:0]       prev1_r;
    logic [DATA_W-1:0]       prev2_r;

    // Working table, slot 0 = largest magnitude.
    logic [DATA_W-1:0]       tab_mag_r [NUM_PEAKS];
    logic [IDX_W-1:0]        tab_idx_r [NUM_PEAKS];
    logic [CNT_W-1:0]        tab_cnt_r;
    logic [DATA_W-1:0]       tab_mag_nxt_s [NUM_PEAKS];
    logic [IDX_W-1:0]        tab_idx_nxt_s [NUM_PEAKS];
    logic [CNT_W-1:0]        tab_cnt_nxt_s;

    // Insertion helpers.
    logic [NUM_PEAKS-1:0]    ge_s;        // slot holds a valid entry >= candidate
    logic [NUM_PEAKS-1:0]    above_ge_s;  // slot above holds such an entry (slot 0: always)
    logic [DATA_W-1:0]       above_mag_s [NUM_PEAKS];
    logic [IDX_W-1:0]        above_idx_s [NUM_PEAKS];

    // Sample decode.
    logic                    start_s;
    logic                    run_sample_s;
    logic                    last_s;
    logic                    detect_s;
    logic [IDX_W-1:0]        cand_idx_s;

    // Result registers.
    logic                    done_r;
    logic [CNT_W-1:0]        peak_count_r;
    logic [IDX_W*NUM_PEAKS-1:0]  peak_index_r;
    logic [DATA_W*NUM_PEAKS-1:0] peak_mag_r;

    assign bus.done       = done_r;
    assign bus.peak_count = peak_count_r;
    assign bus.peak_index = peak_index_r;
    assign bus.peak_mag   = peak_mag_r;

    // Classify the incoming sample and evaluate the peak condition on x[i-1].
    always_comb begin
        start_s      = bus.enable && bus.start;
        run_sample_s = bus.enable && !bus.start && (state_r == ST_RUN);
        last_s       = run_sample_s && (idx_r == LAST_IDX);
        detect_s     = run_sample_s
                    && (idx_r >= IDX_W'(2))
                    && (prev1_r > prev2_r)
                    && (prev1_r >= bus.data_in)
                    && (prev1_r >= bus.thresh);
        cand_idx_s   = idx_r - IDX_W'(1);
    end

    // Next-state logic; a start is honoured in every state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start_s) begin
                    state_nxt_s = ST_RUN;
                end else if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sample index counter and two-deep sample history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_r   <= '0;
            prev1_r <= '0;
            prev2_r <= '0;
        end else if (start_s) begin
            idx_r   <= IDX_W'(1);
            prev1_r <= bus.data_in;
            prev2_r <= '0;
        end else if (run_sample_s) begin
            if (last_s) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
            prev2_r <= prev1_r;
            prev1_r <= bus.data_in;
        end else begin
            idx_r   <= idx_r;
            prev1_r <= prev1_r;
            prev2_r <= prev2_r;
        end
    end

    // Rank the candidate against each slot; sorted table makes ge_s a prefix.
    always_comb begin
        above_ge_s     = '0;
        above_ge_s[0]  = 1'b1;
        above_mag_s[0] = '0;
        above_idx_s[0] = '0;
        for (int s = 0; s < NUM_PEAKS; s++) begin
            ge_s[s] = (CNT_W'(s) < tab_cnt_r) && (tab_mag_r[s] >= prev1_r);
        end
        for (int s = 1; s < NUM_PEAKS; s++) begin
            above_ge_s[s]  = ge_s[s-1];
            above_mag_s[s] = tab_mag_r[s-1];
            above_idx_s[s] = tab_idx_r[s-1];
        end
    end

    // Working table update: clear on start, sorted insert on a detected peak.
    always_comb begin
        for (int s = 0; s < NUM_PEAKS; s++) begin
            tab_mag_nxt_s[s] = tab_mag_r[s];
            tab_idx_nxt_s[s] = tab_idx_r[s];
        end
        tab_cnt_nxt_s = tab_cnt_r;
        if (start_s) begin
            for (int s = 0; s < NUM_PEAKS; s++) begin
                tab_mag_nxt_s[s] = '0;
                tab_idx_nxt_s[s] = '0;
            end
            tab_cnt_nxt_s = '0;
        end else if (detect_s) begin
            for (int s = 0; s < NUM_PEAKS; s++) begin
                if (ge_s[s]) begin
                    tab_mag_nxt_s[s] = tab_mag_r[s];
                    tab_idx_nxt_s[s] = tab_idx_r[s];
                end else if (above_ge_s[s]) begin
                    tab_mag_nxt_s[s] = prev1_r;
                    tab_idx_nxt_s[s] = cand_idx_s;
                end else begin
                    tab_mag_nxt_s[s] = above_mag_s[s];
                    tab_idx_nxt_s[s] = above_idx_s[s];
                end
            end
            // Entry lands in the table and the table still has room.
            if (!ge_s[NUM_PEAKS-1] && (tab_cnt_r != FULL_CNT)) begin
                tab_cnt_nxt_s = tab_cnt_r + CNT_W'(1);
            end else begin
                tab_cnt_nxt_s = tab_cnt_r;
            end
        end else begin
            tab_cnt_nxt_s = tab_cnt_r;
        end
    end

    // Working table registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_PEAKS; s++) begin
                tab_mag_r[s] <= '0;
                tab_idx_r[s] <= '0;
            end
            tab_cnt_r <= '0;
        end else begin
            for (int s = 0; s < NUM_PEAKS; s++) begin
                tab_mag_r[s] <= tab_mag_nxt_s[s];
                tab_idx_r[s] <= tab_idx_nxt_s[s];
            end
            tab_cnt_r <= tab_cnt_nxt_s;
        end
    end

    // Publish the table with a one-cycle done strobe; hold results otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_r       <= 1'b0;
            peak_count_r <= '0;
            peak_index_r <= '0;
            peak_mag_r   <= '0;
        end else if (state_r == ST_DONE) begin
            done_r       <= 1'b1;
            peak_count_r <= tab_cnt_r;
            for (int s = 0; s < NUM_PEAKS; s++) begin
                peak_index_r[s*IDX_W +: IDX_W]   <= tab_idx_r[s];
                peak_mag_r[s*DATA_W +: DATA_W]   <= tab_mag_r[s];
            end
        end else begin
            done_r       <= 1'b0;
            peak_count_r <= peak_count_r;
            peak_index_r <= peak_index_r;
            peak_mag_r   <= peak_mag_r;
        end
    end
endmodule

// File: tb/tb_multi_peak_finder.sv
// Directed, table-driven bench for multi_peak_finder (FRAME_LEN=16, NUM_PEAKS=2).
module tb_multi_peak_finder;
    localparam int DATA_W    = 18;
    localparam int IDX_W     = 12;
    localparam int FRAME_LEN = 16;
    localparam int NUM_PEAKS = 2;
    localparam int CNT_W     = $clog2(NUM_PEAKS + 1);

    typedef logic [FRAME_LEN-1:0][DATA_W-1:0] frame_t;

    typedef struct {
        string             name;
        frame_t            samp;
        logic [DATA_W-1:0] thr;
        bit                gaps;
        int                cnt;
        int                i0;
        int                m0;
        int                i1;
        int                m1;
    } vec_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   done_total;

    multi_peak_finder_if #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_PEAKS(NUM_PEAKS), .CNT_W(CNT_W)
    ) bus ();

    multi_peak_finder #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .FRAME_LEN(FRAME_LEN), .NUM_PEAKS(NUM_PEAKS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_total++;
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int out_idx(input int s);
        return int'(bus.peak_index[s*IDX_W +: IDX_W]);
    endfunction

    function automatic int out_mag(input int s);
        return int'(bus.peak_mag[s*DATA_W +: DATA_W]);
    endfunction

    task automatic check_results(input string nm, input int cnt, input int i0, input int m0,
                                 input int i1, input int m1);
        check({nm, ".count"}, int'(bus.peak_count), cnt);
        check({nm, ".idx0"}, out_idx(0), i0);
        check({nm, ".mag0"}, out_mag(0), m0);
        check({nm, ".idx1"}, out_idx(1), i1);
        check({nm, ".mag1"}, out_mag(1), m1);
    endtask

    task automatic send(input logic en, input logic st, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.enable  = en;
        bus.start   = st;
        bus.data_in = d;
    endtask

    task automatic run_frame(input frame_t f, input logic [DATA_W-1:0] thr, input bit gaps,
                             input int tail);
        bus.thresh = thr;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) send(1'b0, 1'b0, DATA_W'($urandom));
            end
            send(1'b1, (k == 0), f[k]);
        end
        repeat (tail) send(1'b0, 1'b0, '0);
    endtask

    function automatic frame_t spikes(input int a_i, input int a_m, input int b_i, input int b_m,
                                      input int c_i, input int c_m, input int d_i, input int d_m);
        frame_t f;
        f = '0;
        if (a_i >= 0) f[a_i] = DATA_W'(a_m);
        if (b_i >= 0) f[b_i] = DATA_W'(b_m);
        if (c_i >= 0) f[c_i] = DATA_W'(c_m);
        if (d_i >= 0) f[d_i] = DATA_W'(d_m);
        return f;
    endfunction

    initial begin
        vec_t   vecs[10];
        frame_t tri_f;
        frame_t ramp_f;
        frame_t topk_f;
        frame_t plat_f;
        frame_t edge_f;
        int     base;

        total = 0;
        bad   = 0;

        for (int k = 0; k < FRAME_LEN; k++) begin
            ramp_f[k] = DATA_W'(10 * k);
            if (k <= 7)       tri_f[k] = DATA_W'(10 * k);
            else if (k <= 14) tri_f[k] = DATA_W'(60 - 10 * (k - 8));
            else              tri_f[k] = '0;
        end
        topk_f = spikes(3, 50, 7, 90, 11, 70, -1, 0);
        plat_f = spikes(4, 60, 5, 60, 10, 60, -1, 0);
        edge_f = spikes(0, 99, 2, 40, 15, 99, -1, 0);

        vecs[0] = '{"single",  tri_f,  18'd0,  1'b0, 1, 7, 70, 0, 0};
        vecs[1] = '{"ramp",    ramp_f, 18'd0,  1'b0, 0, 0, 0, 0, 0};
        vecs[2] = '{"topk",    topk_f, 18'd0,  1'b0, 2, 7, 90, 11, 70};
        vecs[3] = '{"thr80",   topk_f, 18'd80, 1'b0, 1, 7, 90, 0, 0};
        vecs[4] = '{"thr_eq",  topk_f, 18'd70, 1'b0, 2, 7, 90, 11, 70};
        vecs[5] = '{"plateau", plat_f, 18'd0,  1'b0, 2, 4, 60, 10, 60};
        vecs[6] = '{"drop_tie", spikes(2, 30, 5, 80, 8, 40, 12, 80), 18'd0, 1'b0, 2, 5, 80, 12, 80};
        vecs[7] = '{"ends",    edge_f, 18'd0,  1'b0, 1, 2, 40, 0, 0};
        vecs[8] = '{"inner",   spikes(1, 50, 14, 50, -1, 0, -1, 0), 18'd0, 1'b0, 2, 1, 50, 14, 50};
        vecs[9] = '{"gaps",    topk_f, 18'd0,  1'b1, 2, 7, 90, 11, 70};

        // Reset state.
        reset_n     = 1'b0;
        bus.enable  = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
        bus.thresh  = '0;
        repeat (2) @(negedge clk);
        check("rst.done", int'(bus.done), 0);
        check_results("rst", 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        // Table-driven frames.
        for (int v = 0; v < 10; v++) begin
            base = done_total;
            run_frame(vecs[v].samp, vecs[v].thr, vecs[v].gaps, 3);
            check({vecs[v].name, ".done_pulses"}, done_total - base, 1);
            check_results(vecs[v].name, vecs[v].cnt, vecs[v].i0, vecs[v].m0, vecs[v].i1, vecs[v].m1);
        end

        // Done latency: low one cycle after the last sample, high the next, then low.
        run_frame(plat_f, '0, 1'b0, 0);
        send(1'b0, 1'b0, '0);
        check("lat.e0", int'(bus.done), 0);
        send(1'b0, 1'b0, '0);
        check("lat.e1", int'(bus.done), 1);
        check_results("lat", 2, 4, 60, 10, 60);
        send(1'b0, 1'b0, '0);
        check("lat.e2", int'(bus.done), 0);

        // Back-to-back frames: start lands during DONE; results hold mid-frame.
        base = done_total;
        run_frame(topk_f, '0, 1'b0, 0);
        for (int k = 0; k < FRAME_LEN; k++) begin
            send(1'b1, (k == 0), tri_f[k]);
            if (k == 1) begin
                check("b2b.first_done", int'(bus.done), 1);
                check_results("b2b.first", 2, 7, 90, 11, 70);
            end
            if (k == 9) check_results("b2b.hold", 2, 7, 90, 11, 70);
        end
        repeat (3) send(1'b0, 1'b0, '0);
        check("b2b.done_pulses", done_total - base, 2);
        check_results("b2b.second", 1, 7, 70, 0, 0);

        // Restart at index 9: old frame discarded, new frame counts 16 from restart.
        base = done_total;
        bus.thresh = '0;
        for (int k = 0; k < 9; k++) send(1'b1, (k == 0), topk_f[k]);
        for (int k = 0; k < FRAME_LEN - 1; k++) send(1'b1, (k == 0), plat_f[k]);
        repeat (3) send(1'b0, 1'b0, '0);
        check("restart.no_early_done", done_total - base, 0);
        send(1'b1, 1'b0, plat_f[FRAME_LEN-1]);
        repeat (3) send(1'b0, 1'b0, '0);
        check("restart.done_pulses", done_total - base, 1);
        check_results("restart", 2, 4, 60, 10, 60);

        // Reset mid-frame: outputs clear at once, no done, then recovery.
        base = done_total;
        for (int k = 0; k < 6; k++) send(1'b1, (k == 0), topk_f[k]);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.done", int'(bus.done), 0);
        check_results("midrst", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < FRAME_LEN; k++) send(1'b1, 1'b0, topk_f[k]);
        repeat (3) send(1'b0, 1'b0, '0);
        check("midrst.no_done", done_total - base, 0);
        run_frame(topk_f, 18'd80, 1'b0, 3);
        check("midrst.done_pulses", done_total - base, 1);
        check_results("midrst.clean", 1, 7, 90, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
